// File: rtl/iobuf_sync_pkg.sv
// Shared types and helpers for the synchronous bidirectional pad controller.
// Optional bus keeper on the receive path is enabled with IOBUF_SYNC_CTRL_KEEPER_EN.
package iobuf_sync_pkg;

  typedef enum logic [1:0] {
    MODE_HIZ  = 2'd0,
    MODE_TX   = 2'd1,
    MODE_RX   = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_HIZ  = 2'd0,
    ST_TX   = 2'd1,
    ST_RX   = 2'd2,
    ST_TURN = 2'd3
  } state_e;

  localparam int TURN_W = 4;

  // Reserved requests fold onto HIZ so they can never cause a drive.
  function automatic logic [1:0] mode_to_state(input logic [1:0] m);
    logic [1:0] s;
    case (m)
      MODE_TX: s = ST_TX;
      MODE_RX: s = ST_RX;
      default: s = ST_HIZ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/iobuf_sync_rxpipe.sv
// Receive sampling pipeline: STAGES registers of pad data with a valid tag.
// With IOBUF_SYNC_CTRL_KEEPER_EN, undriven/unknown bits hold the last rx_data bit.
module iobuf_sync_rxpipe
  import iobuf_sync_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
`ifdef IOBUF_SYNC_CTRL_KEEPER_EN
  , output logic           keeper_hit
`endif
);

  logic [WIDTH-1:0] data_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0] din;

`ifdef IOBUF_SYNC_CTRL_KEEPER_EN
  logic hit;

  always_comb begin
    din = sample;
    hit = 1'b0;
    if (sample_valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sample[i] !== 1'b0 && sample[i] !== 1'b1) begin
          din[i] = data_q[STAGES-1][i];
          hit    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) keeper_hit <= 1'b0;
    else       keeper_hit <= hit;
  end
`else
  assign din = sample;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      vld_q <= '0;
    end else begin
      data_q[0] <= din;
      vld_q[0]  <= sample_valid;
      for (int i = 1; i < STAGES; i++) begin
        data_q[i] <= data_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign rx_data  = data_q[STAGES-1];
  assign rx_valid = vld_q[STAGES-1];

endmodule

// File: rtl/iobuf_sync_ctrl.sv
// Bidirectional pad controller with mode handshake and hi-Z turnaround.
// Build option IOBUF_SYNC_CTRL_KEEPER_EN adds a bus keeper and the keeper_hit output.
module iobuf_sync_ctrl
  import iobuf_sync_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int RX_STAGES   = 1
) (
  input  logic             clock,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] pad,
  input  logic [1:0]       mode_req,
  input  logic             mode_valid,
  output logic             mode_ack,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             pad_oe,
  output logic [1:0]       state
`ifdef IOBUF_SYNC_CTRL_KEEPER_EN
  , output logic           keeper_hit
`endif
);

  localparam logic [1:0] S_HIZ  = ST_HIZ;
  localparam logic [1:0] S_TX   = ST_TX;
  localparam logic [1:0] S_RX   = ST_RX;
  localparam logic [1:0] S_TURN = ST_TURN;

  // Handshakes: a mode request is taken when mode_valid & mode_ack (any
  // non-TURN state); a tx word is taken when tx_valid & tx_ready (TX only).
  logic [1:0]        state_q, state_d, tgt_q, tgt_d, req_st;
  logic [TURN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  tx_q;

  assign req_st   = mode_to_state(mode_req);
  assign mode_ack = mode_valid && (state_q != S_TURN);
  assign tx_ready = (state_q == S_TX);
  assign state    = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    case (state_q)
      S_TURN: begin
        if (cnt_q == '0) state_d = tgt_q;
        else             cnt_d   = cnt_q - TURN_W'(1);
      end
      default: begin
        if (mode_valid && req_st != state_q) begin
          // Anything touching TX goes through the dead band; HIZ<->RX is direct.
          if (state_q == S_TX || req_st == S_TX) begin
            if (TURN_CYCLES == 0) begin
              state_d = req_st;
            end else begin
              state_d = S_TURN;
              cnt_d   = TURN_W'(TURN_CYCLES - 1);
              tgt_d   = req_st;
            end
          end else begin
            state_d = req_st;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_HIZ;
      tgt_q   <= S_HIZ;
      cnt_q   <= '0;
      pad_oe  <= 1'b0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      pad_oe  <= (state_d == S_TX);
      if (tx_valid && tx_ready) tx_q <= tx_data;
    end
  end

  assign pad = pad_oe ? tx_q : {WIDTH{1'bz}};

  iobuf_sync_rxpipe #(
    .WIDTH  (WIDTH),
    .STAGES (RX_STAGES)
  ) u_rxpipe (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (state_q == S_RX),
    .sample       (pad),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid)
`ifdef IOBUF_SYNC_CTRL_KEEPER_EN
    , .keeper_hit (keeper_hit)
`endif
  );

endmodule
